regfile_controller: RTL and testbench
=====================================

REGFILE_CONTROLLER -- requirements
Module: regfile_controller

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- DATA_W, 8, register data width
- ADDR_W, 2, register select width
- READ_LAT, 1, cycles the read strobe is held before `out` is sampled; legal range 1..15
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
- clk, in, 1, single clock; all state updates on its rising edge
- rst, in, 1, asynchronous, active-low reset
- cmd_valid, in, 1, upstream command present
- cmd_ready, out, 1, controller can accept a command
- cmd_write, in, 1, 1 = write, 0 = read
- cmd_addr, in, ADDR_W, target register
- cmd_data, in, DATA_W, write data
- rsp_valid, out, 1, response present
- rsp_ready, in, 1, upstream accepts response
- rsp_write, out, 1, response belongs to a write
- rsp_data, out, DATA_W, read data; 0 for writes
- busy, out, 1, high whenever state is not IDLE
- reg_on, out, 1, register file enable
- read_write, out, 2, 01 = write, 10 = read, 00 = idle; 11 is never driven
- rw_reg, out, ADDR_W, register select to the register file
- in, out, DATA_W, write data to the register file
- out, in, DATA_W, read data from the register file

Function
REQ-003 The FSM SHALL have exactly four states: IDLE, WRITE, READ, RESP.
REQ-004 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted on a rising edge with cmd_valid and cmd_ready both 1.
REQ-005 On acceptance, the controller SHALL latch cmd_write, cmd_addr and cmd_data, then go to WRITE if cmd_write = 1, else to READ.
REQ-006 Upstream changes to the cmd_* inputs after acceptance SHALL have no effect on the transaction in progress.
REQ-007 WRITE SHALL last exactly 1 cycle, driving reg_on = 1, read_write = 01, rw_reg = latched addr, in = latched data; it SHALL then go to RESP with rsp_write = 1 and rsp_data = 0.
REQ-008 READ SHALL last exactly READ_LAT cycles, driving reg_on = 1, read_write = 10, rw_reg = latched addr; a 4-bit counter SHALL time this.
REQ-009 On the edge ending the last READ cycle, `out` SHALL be captured into rsp_data, rsp_write SHALL be set to 0, and the FSM SHALL go to RESP.
REQ-010 In IDLE and RESP, reg_on SHALL be 0 and read_write SHALL be 00; rw_reg and `in` SHALL hold their last driven values.
REQ-011 All bus outputs (reg_on, read_write, rw_reg, in) SHALL be registered and SHALL change only on clk edges.
REQ-012 RESP SHALL drive rsp_valid = 1 and hold rsp_data and rsp_write stable until rsp_valid and rsp_ready are both 1 on an edge, then go to IDLE.
REQ-013 rsp_valid SHALL be 0 in every state other than RESP.
REQ-014 Latency from the acceptance edge to rsp_valid high SHALL be 1 cycle for a write and READ_LAT cycles for a read.
REQ-015 Throughput: the minimum command-to-command spacing SHALL be 3 cycles for writes and READ_LAT + 2 cycles for reads (rsp_ready held high).
REQ-016 No new command SHALL be accepted while a response is pending; back-pressure holds cmd_ready at 0 indefinitely.
REQ-017 busy SHALL equal (state != IDLE).

Reset
REQ-018 While rst = 0, the block SHALL immediately go to IDLE, regardless of clk, and drive these values:
- state IDLE, cmd_ready 1, rsp_valid 0, rsp_write 0, rsp_data 0, busy 0
- reg_on 0, read_write 00, rw_reg 0, in 0
- read counter 0
REQ-019 A transaction interrupted by reset SHALL be abandoned with no response and no further bus activity.
REQ-020 The first command SHALL be accepted no earlier than the first rising edge with rst = 1.

Verification
REQ-021 Write: cmd_write = 1, cmd_addr = 2, cmd_data = 0x18 -> one cycle of reg_on = 1, read_write = 01, rw_reg = 10, in = 0x18; then rsp_valid = 1, rsp_write = 1, rsp_data = 0.
REQ-022 Read, READ_LAT = 1: cmd_write = 0, cmd_addr = 2, out = 0x18 -> one cycle of read_write = 10, rw_reg = 10; then rsp_valid = 1, rsp_data = 0x18, rsp_write = 0.
REQ-023 Read, READ_LAT = 3: read strobe held exactly 3 cycles; `out` changes in the 2nd strobe cycle are ignored, and the value present in the 3rd strobe cycle is returned.
REQ-024 Back-pressure: rsp_ready held 0 for 4 cycles -> rsp_valid and rsp_data stable, cmd_ready = 0 and read_write = 00 throughout; IDLE follows the handshake edge.
REQ-025 Reset mid-read: rst driven 0 in the middle of READ -> asynchronously all outputs take their REQ-018 values; no rsp_valid pulse occurs after rst returns to 1.
REQ-026 Back-to-back traffic: write 0xA5 to reg 1, then read reg 1 with rsp_ready tied 1 and a register-file model -> rsp_data = 0xA5; spacing matches REQ-015; read_write never equals 11.

Source files
------------

// File: rtl/regfile_controller_if.sv
// Command/response handshake and register-file bus bundle for
// regfile_controller. master = upstream/regfile side, slave = controller.
interface regfile_controller_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_data;
  logic              busy;
  logic              reg_on;
  logic [1:0]        read_write;
  logic [ADDR_W-1:0] rw_reg;
  logic [DATA_W-1:0] in;
  logic [DATA_W-1:0] out;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_data,
    output rsp_ready, out,
    input  cmd_ready, rsp_valid, rsp_write, rsp_data,
    input  busy, reg_on, read_write, rw_reg, in
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_data,
    input  rsp_ready, out,
    output cmd_ready, rsp_valid, rsp_write, rsp_data,
    output busy, reg_on, read_write, rw_reg, in
  );
endinterface

// File: rtl/regfile_controller.sv
// Single-command register-file controller: accepts one write/read,
// strobes the register file, returns one response, then re-arms.
module regfile_controller #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 2,
  parameter int READ_LAT = 1
) (
  input logic clk,
  input logic rst,
  regfile_controller_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [1:0] RW_IDLE = 2'b00;
  localparam logic [1:0] RW_WR   = 2'b01;
  localparam logic [1:0] RW_RD   = 2'b10;
  localparam logic [3:0] LAST    = 4'(READ_LAT - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_write_q, rsp_write_d;
  logic              reg_on_q, reg_on_d;
  logic [1:0]        rw_q, rw_d;
  logic [ADDR_W-1:0] rw_reg_q, rw_reg_d;
  logic [DATA_W-1:0] in_q, in_d;

  // rw_reg_q/in_q double as the latched command, so cmd_* is
  // only looked at on the acceptance edge.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_write_d = rsp_write_q;
    reg_on_d    = 1'b0;
    rw_d        = RW_IDLE;
    rw_reg_d    = rw_reg_q;
    in_d        = in_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          reg_on_d = 1'b1;
          rw_reg_d = bus.cmd_addr;
          cnt_d    = 4'd0;
          if (bus.cmd_write) begin
            state_d = WRITE;
            rw_d    = RW_WR;
            in_d    = bus.cmd_data;
          end else begin
            state_d = READ;
            rw_d    = RW_RD;
          end
        end
      end
      WRITE: begin
        state_d     = RESP;
        rsp_write_d = 1'b1;
        rsp_data_d  = '0;
      end
      READ: begin
        if (cnt_q == LAST) begin
          state_d     = RESP;
          rsp_data_d  = bus.out;
          rsp_write_d = 1'b0;
          cnt_d       = 4'd0;
        end else begin
          cnt_d    = cnt_q + 4'd1;
          reg_on_d = 1'b1;
          rw_d     = RW_RD;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rsp_data_q  <= '0;
      rsp_write_q <= 1'b0;
      reg_on_q    <= 1'b0;
      rw_q        <= RW_IDLE;
      rw_reg_q    <= '0;
      in_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_write_q <= rsp_write_d;
      reg_on_q    <= reg_on_d;
      rw_q        <= rw_d;
      rw_reg_q    <= rw_reg_d;
      in_q        <= in_d;
    end
  end

  assign bus.cmd_ready  = (state_q == IDLE);
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.busy       = (state_q != IDLE);
  assign bus.rsp_write  = rsp_write_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.reg_on     = reg_on_q;
  assign bus.read_write = rw_q;
  assign bus.rw_reg     = rw_reg_q;
  assign bus.in         = in_q;

endmodule

// File: tb/tb_regfile_controller.sv
// Directed bench for regfile_controller: READ_LAT=1 and READ_LAT=3
// instances sharing clock and reset.
module tb_regfile_controller;

  logic clk;
  logic rst;
  int   nchk;
  int   nerr;

  regfile_controller_if #(.DATA_W(8), .ADDR_W(2)) if_a ();
  regfile_controller_if #(.DATA_W(8), .ADDR_W(2)) if_b ();

  regfile_controller #(.DATA_W(8), .ADDR_W(2), .READ_LAT(1)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.slave)
  );

  regfile_controller #(.DATA_W(8), .ADDR_W(2), .READ_LAT(3)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.slave)
  );

  logic [7:0] mem [4];
  logic       use_model;
  logic [7:0] out_a;
  logic       bad_rw;

  always @(posedge clk) begin
    if (if_a.reg_on && if_a.read_write == 2'b01) mem[if_a.rw_reg] <= if_a.in;
  end

  always_comb if_a.out = use_model ? mem[if_a.rw_reg] : out_a;

  always @(negedge clk) begin
    if (if_a.read_write == 2'b11 || if_b.read_write == 2'b11) bad_rw = 1'b1;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_rst(input string p);
    chk({p, "_rst_ready"}, 32'(if_b.cmd_ready), 32'd1);
    chk({p, "_rst_busy"},  32'(if_b.busy), 32'd0);
    chk({p, "_rst_rvld"},  32'(if_b.rsp_valid), 32'd0);
    chk({p, "_rst_rwr"},   32'(if_b.rsp_write), 32'd0);
    chk({p, "_rst_rdata"}, 32'(if_b.rsp_data), 32'd0);
    chk({p, "_rst_regon"}, 32'(if_b.reg_on), 32'd0);
    chk({p, "_rst_rw"},    32'(if_b.read_write), 32'd0);
    chk({p, "_rst_rwreg"}, 32'(if_b.rw_reg), 32'd0);
    chk({p, "_rst_in"},    32'(if_b.in), 32'd0);
  endtask

  int         acc_t [2];
  int         n_acc;
  logic       seen;
  logic [7:0] got_rd;
  logic       flag;

  initial begin
    nchk = 0; nerr = 0; bad_rw = 1'b0;
    use_model = 1'b0; out_a = 8'h00;
    for (int i = 0; i < 4; i++) mem[i] = 8'h00;
    if_a.cmd_valid = 0; if_a.cmd_write = 0; if_a.cmd_addr = 0;
    if_a.cmd_data = 0; if_a.rsp_ready = 0;
    if_b.cmd_valid = 0; if_b.cmd_write = 0; if_b.cmd_addr = 0;
    if_b.cmd_data = 0; if_b.rsp_ready = 0; if_b.out = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #2;
    chk_rst("init");
    chk("init_a_ready", 32'(if_a.cmd_ready), 32'd1);
    @(negedge clk);
    @(negedge clk) rst = 1'b1;

    // write reg 2 <= 0x18, cmd changed after acceptance
    if_a.cmd_valid = 1; if_a.cmd_write = 1;
    if_a.cmd_addr = 2; if_a.cmd_data = 8'h18;
    @(negedge clk);
    if_a.cmd_valid = 0; if_a.cmd_addr = 0; if_a.cmd_data = 8'hFF;
    chk("wr_busy",  32'(if_a.busy), 32'd1);
    chk("wr_ready", 32'(if_a.cmd_ready), 32'd0);
    chk("wr_regon", 32'(if_a.reg_on), 32'd1);
    chk("wr_rw",    32'(if_a.read_write), 32'h1);
    chk("wr_rwreg", 32'(if_a.rw_reg), 32'd2);
    chk("wr_in",    32'(if_a.in), 32'h18);
    chk("wr_rvld",  32'(if_a.rsp_valid), 32'd0);
    @(negedge clk);
    chk("wrr_rvld",  32'(if_a.rsp_valid), 32'd1);
    chk("wrr_rwr",   32'(if_a.rsp_write), 32'd1);
    chk("wrr_rdata", 32'(if_a.rsp_data), 32'd0);
    chk("wrr_regon", 32'(if_a.reg_on), 32'd0);
    chk("wrr_rw",    32'(if_a.read_write), 32'd0);
    chk("wrr_rwreg", 32'(if_a.rw_reg), 32'd2);
    chk("wrr_in",    32'(if_a.in), 32'h18);
    if_a.rsp_ready = 1;
    @(negedge clk);
    if_a.rsp_ready = 0;
    chk("wr_done_rvld", 32'(if_a.rsp_valid), 32'd0);
    chk("wr_done_busy", 32'(if_a.busy), 32'd0);

    // read reg 2, READ_LAT=1
    if_a.cmd_valid = 1; if_a.cmd_write = 0;
    if_a.cmd_addr = 2; out_a = 8'h18;
    @(negedge clk);
    if_a.cmd_valid = 0;
    chk("rd_rw",    32'(if_a.read_write), 32'h2);
    chk("rd_rwreg", 32'(if_a.rw_reg), 32'd2);
    chk("rd_regon", 32'(if_a.reg_on), 32'd1);
    chk("rd_rvld",  32'(if_a.rsp_valid), 32'd0);
    @(negedge clk);
    out_a = 8'h33;
    if_a.cmd_valid = 1; if_a.cmd_write = 1;
    chk("rdr_rvld",  32'(if_a.rsp_valid), 32'd1);
    chk("rdr_rdata", 32'(if_a.rsp_data), 32'h18);
    chk("rdr_rwr",   32'(if_a.rsp_write), 32'd0);
    // back-pressure: response held, new command refused
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("bp_rvld",  32'(if_a.rsp_valid), 32'd1);
      chk("bp_rdata", 32'(if_a.rsp_data), 32'h18);
      chk("bp_ready", 32'(if_a.cmd_ready), 32'd0);
      chk("bp_rw",    32'(if_a.read_write), 32'd0);
    end
    if_a.cmd_valid = 0; if_a.rsp_ready = 1;
    @(negedge clk);
    if_a.rsp_ready = 0;
    chk("bp_done_rvld",  32'(if_a.rsp_valid), 32'd0);
    chk("bp_done_ready", 32'(if_a.cmd_ready), 32'd1);

    // READ_LAT=3: only the 3rd strobe cycle's value is returned
    if_b.cmd_valid = 1; if_b.cmd_write = 0;
    if_b.cmd_addr = 1; if_b.out = 8'h11;
    @(negedge clk);
    if_b.cmd_valid = 0;
    chk("l3_rw1", 32'(if_b.read_write), 32'h2);
    @(negedge clk);
    if_b.out = 8'h22;
    chk("l3_rw2", 32'(if_b.read_write), 32'h2);
    chk("l3_rwreg", 32'(if_b.rw_reg), 32'd1);
    @(negedge clk);
    if_b.out = 8'h5C;
    chk("l3_rw3",   32'(if_b.read_write), 32'h2);
    chk("l3_rvld3", 32'(if_b.rsp_valid), 32'd0);
    @(negedge clk);
    if_b.out = 8'h77;
    chk("l3_rvld",  32'(if_b.rsp_valid), 32'd1);
    chk("l3_rdata", 32'(if_b.rsp_data), 32'h5C);
    chk("l3_rw",    32'(if_b.read_write), 32'd0);
    if_b.rsp_ready = 1;
    @(negedge clk);
    if_b.rsp_ready = 0;
    chk("l3_done_busy", 32'(if_b.busy), 32'd0);

    // reset in the middle of a READ_LAT=3 read
    if_b.cmd_valid = 1; if_b.cmd_write = 0; if_b.cmd_addr = 3;
    @(negedge clk);
    if_b.cmd_valid = 0;
    chk("mr_rw", 32'(if_b.read_write), 32'h2);
    #2 rst = 1'b0;
    #1;
    chk_rst("mid");
    @(negedge clk) rst = 1'b1;
    if_b.rsp_ready = 1;
    flag = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (if_b.rsp_valid || if_b.read_write != 2'b00) flag = 1'b1;
    end
    if_b.rsp_ready = 0;
    chk("mr_quiet", 32'(flag), 32'd0);

    // back-to-back write 0xA5 to reg 1 then read reg 1, model-backed
    use_model = 1; if_a.rsp_ready = 1;
    if_a.cmd_valid = 1; if_a.cmd_write = 1;
    if_a.cmd_addr = 1; if_a.cmd_data = 8'hA5;
    n_acc = 0; seen = 0; got_rd = 8'h00;
    for (int i = 0; i < 20; i++) begin
      if (if_a.cmd_valid && if_a.cmd_ready && n_acc < 2) begin
        acc_t[n_acc] = i;
        n_acc++;
      end
      @(negedge clk);
      if (n_acc == 1) begin
        if_a.cmd_write = 0; if_a.cmd_data = 8'h00;
      end
      if (n_acc == 2) if_a.cmd_valid = 0;
      if (!seen && if_a.rsp_valid && !if_a.rsp_write) begin
        seen = 1; got_rd = if_a.rsp_data;
      end
    end
    chk("b2b_accepts", 32'(n_acc), 32'd2);
    if (n_acc == 2) chk("b2b_spacing", 32'(acc_t[1] - acc_t[0]), 32'd3);
    chk("b2b_seen",  32'(seen), 32'd1);
    chk("b2b_rdata", 32'(got_rd), 32'hA5);
    chk("rw_never_11", 32'(bad_rw), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
